clk_div_ctrl: RTL



---
 rtl/clk_div_ctrl_pkg.sv | 13 +
 rtl/clk_div_core.sv | 46 ++++
 rtl/clk_div_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the run-time clock-divider controller.
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV      = 2;
    localparam int unsigned PERIOD_CNT_W = 32;

endpackage

// File: rtl/clk_div_core.sv
// Divide counter plus glitch-free clk_out and per-period tick generation.
module clk_div_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] div,
    output logic             wrap,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] last_cnt;
    logic [WIDTH-1:0] rise_cnt;

    always_comb begin
        last_cnt = div - WIDTH'(1);
        rise_cnt = (div >> 1) - WIDTH'(1);
        wrap     = en && (cnt == last_cnt);
    end

    // Counter is parked at zero with clk_out low whenever not running.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (clear || !en) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + WIDTH'(1);
            tick <= wrap;
            if (wrap) begin
                clk_out <= 1'b0;
            end else if (cnt == rise_cnt) begin
                clk_out <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop sequencing and ratio handshake around clk_div_core.
// Optional completed-period counter: define CLK_DIV_CTRL_PERIOD_CNT_EN.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [WIDTH-1:0]        div_val,
    input  logic                    div_valid,
    output logic                    div_ready,
    output logic                    clk_out,
    output logic                    tick,
    output logic                    busy,
    output logic                    err,
    output logic [PERIOD_CNT_W-1:0] period_cnt
);

    state_t           state;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] pending;
    logic             wrap;
    logic             en;
    logic             clear;
    logic             apply;
    logic             xfer;

    always_comb begin
        en    = (state != ST_IDLE);
        clear = (state == ST_IDLE) && start && !stop;
        // div_ready low means the pending slot holds a ratio
        apply = !div_ready && ((state == ST_IDLE) || wrap);
        xfer  = div_valid && div_ready;
    end

    clk_div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_in  (clk_in),
        .reset   (reset),
        .en      (en),
        .clear   (clear),
        .div     (div),
        .wrap    (wrap),
        .clk_out (clk_out),
        .tick    (tick)
    );

    // Run-control FSM and ratio handshake; stop always beats start.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            err       <= 1'b0;
            div       <= WIDTH'(DEFAULT_DIV);
            pending   <= '0;
            div_ready <= 1'b1;
        end else begin
            err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_STOPPING;
                    end
                end
                ST_STOPPING: begin
                    if (start && !stop) begin
                        state <= ST_RUN;
                    end else if (wrap) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (apply) begin
                div       <= pending;
                div_ready <= 1'b1;
            end

            if (xfer) begin
                if (div_val >= WIDTH'(MIN_DIV)) begin
                    pending   <= div_val;
                    div_ready <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [PERIOD_CNT_W-1:0] period_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            period_q <= '0;
        end else if (tick) begin
            period_q <= period_q + PERIOD_CNT_W'(1);
        end
    end

    assign period_cnt = period_q;
`else
    assign period_cnt = '0;
`endif

endmodule
